// File: rtl/ft60x_bus_scheduler_pkg.sv
// FT60x bus scheduler shared types.
// State encoding and grant direction for the half-duplex bus FSM.
package ft60x_bus_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_OE,
    S_RX_RD,
    S_RX_END,
    S_TX_TURN,
    S_TX_WR,
    S_TX_END
  } state_e;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_e;

endpackage

// File: rtl/ft60x_bus_scheduler.sv
// FT60x 245-sync-FIFO half-duplex bus scheduler (usb_clk domain).
// Ports: chip strobes/flags and bus, TX FWFT FIFO read side,
// RX FIFO write side, busy/dir_rx status.
module ft60x_bus_scheduler
  import ft60x_bus_scheduler_pkg::*;
#(
  parameter int FIFO_BUS_WIDTH = 2,
  parameter int MAX_BURST      = 256
) (
  input  logic                        usb_clk,
  input  logic                        rst_glbl,
  input  logic                        usb_txe_n,
  input  logic                        usb_rxf_n,
  output logic                        usb_wr_n,
  output logic                        usb_rd_n,
  output logic                        usb_oe_n,
  input  logic [FIFO_BUS_WIDTH*8-1:0] usb_data_i,
  input  logic [FIFO_BUS_WIDTH-1:0]   usb_be_i,
  output logic [FIFO_BUS_WIDTH*8-1:0] usb_data_o,
  output logic [FIFO_BUS_WIDTH-1:0]   usb_be_o,
  output logic                        usb_data_t,
  output logic                        usb_be_t,
  input  logic                        tx_empty,
  input  logic [FIFO_BUS_WIDTH*8-1:0] tx_dout,
  input  logic [FIFO_BUS_WIDTH-1:0]   tx_be,
  output logic                        tx_rd_en,
  input  logic                        rx_prog_full,
  output logic                        rx_wr_en,
  output logic [FIFO_BUS_WIDTH*8-1:0] rx_din,
  output logic [FIFO_BUS_WIDTH-1:0]   rx_be,
  output logic                        busy,
  output logic                        dir_rx
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] MAXC = BCNT_W'(MAX_BURST);

  state_e            state;
  grant_e            last_grant;
  logic [BCNT_W-1:0] burst_cnt;
  logic              oe_q;
  logic              rd_q;
  logic              t_q;

  logic              rx_req;
  logic              tx_req;
  logic              tx_ok;
  logic              rx_last;
  logic              tx_last;
  logic [BCNT_W-1:0] cnt_inc;

  assign rx_req = !usb_rxf_n && !rx_prog_full;
  assign tx_req = !usb_txe_n && !tx_empty;

  assign usb_oe_n   = oe_q;
  assign usb_rd_n   = rd_q;
  assign usb_data_t = t_q;
  assign usb_be_t   = t_q;
  assign usb_data_o = tx_dout;
  assign usb_be_o   = tx_be;
  assign rx_din     = usb_data_i;
  assign rx_be      = usb_be_i;

  // Write strobe follows the FIFO head so a word is never
  // presented when the FIFO runs dry mid-tenure.
  assign tx_ok    = (state == S_TX_WR) && !tx_empty
                    && (burst_cnt < MAXC);
  assign usb_wr_n = !tx_ok;
  assign tx_rd_en = tx_ok && !usb_txe_n;
  assign rx_wr_en = !rd_q && !usb_rxf_n;

  // Count including this cycle's transfer, so the limit is
  // detected on the word that reaches it.
  assign cnt_inc = burst_cnt + BCNT_W'(rx_wr_en | tx_rd_en);
  assign rx_last = usb_rxf_n || rx_prog_full || (cnt_inc == MAXC);
  assign tx_last = usb_txe_n || tx_empty || (cnt_inc == MAXC);

  assign busy   = (state != S_IDLE);
  assign dir_rx = (state == S_RX_OE) || (state == S_RX_RD)
                  || (state == S_RX_END);

  always_ff @(posedge usb_clk or posedge rst_glbl) begin
    if (rst_glbl) begin
      state      <= S_IDLE;
      last_grant <= GRANT_TX;
      burst_cnt  <= '0;
      oe_q       <= 1'b1;
      rd_q       <= 1'b1;
      t_q        <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          burst_cnt <= '0;
          // Contested grant alternates away from the last winner.
          if (rx_req && (!tx_req || last_grant == GRANT_TX)) begin
            state      <= S_RX_OE;
            oe_q       <= 1'b0;
            last_grant <= GRANT_RX;
          end else if (tx_req) begin
            state      <= S_TX_TURN;
            t_q        <= 1'b0;
            last_grant <= GRANT_TX;
          end
        end
        S_RX_OE: begin
          state <= S_RX_RD;
          rd_q  <= 1'b0;
        end
        S_RX_RD: begin
          burst_cnt <= cnt_inc;
          if (rx_last) begin
            state <= S_RX_END;
            rd_q  <= 1'b1;
            oe_q  <= 1'b1;
          end
        end
        S_RX_END: begin
          state <= S_IDLE;
        end
        S_TX_TURN: begin
          state <= S_TX_WR;
        end
        S_TX_WR: begin
          burst_cnt <= cnt_inc;
          if (tx_last) begin
            state <= S_TX_END;
            t_q   <= 1'b1;
          end
        end
        S_TX_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
